mtsp_memory_command_issue: RTL and testbench

- Encoder/issuer side of the MTSP 128-bit memory command word; the command dispatch stage is its consumer.
- Takes one field-level request describing a block of transfers.
- Expands it into req_count consecutive commands whose id runs req_id, req_id+1, ...
- Packs each command into the DWORDx4 layout and queues it in an output FIFO drained over a valid/ready handshake.

---
 rtl/mtsp_memory_command_issue.sv | 115 +++++++++++
 tb/tb_mtsp_memory_command_issue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mtsp_memory_command_issue.sv
// mtsp_memory_command_issue: expands a block request into packed 128-bit memory commands queued in an output FIFO.
// Optional MTSP_MEMCMD_ISSUE_STAT_EN adds stat_issued/stat_stall counters.
module mtsp_memory_command_issue #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_flags,
    input  logic [11:0]  req_index,
    input  logic [15:0]  req_id,
    input  logic [15:0]  req_count,
    input  logic [15:0]  req_mask,
    input  logic [7:0]   req_stride,
    input  logic [7:0]   req_size,
    input  logic [31:0]  req_pbase,
    input  logic [15:0]  req_lbase,
    input  logic [15:0]  req_gbase,
    output logic         cmd_valid,
    input  logic         cmd_ready,
    output logic [127:0] cmd,
    output logic         busy
`ifdef MTSP_MEMCMD_ISSUE_STAT_EN
    ,
    output logic [31:0]  stat_issued,
    output logic [31:0]  stat_stall
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state, state_nxt;
    logic [3:0]   flags_q;
    logic [11:0]  index_q;
    logic [15:0]  id_q, remain_q, mask_q, lbase_q, gbase_q;
    logic [7:0]   stride_q, size_q;
    logic [31:0]  pbase_q;
    logic [127:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]  count;
    logic full, empty, accept, push, pop;
    assign full   = count == (AW+1)'(FIFO_DEPTH);
    assign empty  = count == '0;
    assign accept = req_valid & req_ready;
    assign push   = (state == ISSUE) & !full;
    assign pop    = cmd_valid & cmd_ready;
    always_ff @(posedge CLK) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nxt;
    end
    // The push that consumes the last remaining command returns to IDLE on the same edge.
    always_comb begin
        state_nxt = (state == IDLE) ? ((accept && req_count != '0) ? ISSUE : IDLE)
                                    : ((push && remain_q == 16'd1) ? IDLE : ISSUE);
    end
    always_comb begin
        req_ready = state == IDLE;
        cmd_valid = !empty;
        cmd       = empty ? '0 : mem[rd_ptr];
        busy      = (state == ISSUE) | !empty;
    end
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            flags_q  <= '0;
            index_q  <= '0;
            id_q     <= '0;
            remain_q <= '0;
            mask_q   <= '0;
            stride_q <= '0;
            size_q   <= '0;
            pbase_q  <= '0;
            lbase_q  <= '0;
            gbase_q  <= '0;
        end else if (accept) begin
            flags_q  <= req_flags;
            index_q  <= req_index;
            id_q     <= req_id;
            remain_q <= req_count;
            mask_q   <= req_mask;
            stride_q <= req_stride;
            size_q   <= req_size;
            pbase_q  <= req_pbase;
            lbase_q  <= req_lbase;
            gbase_q  <= req_gbase;
        end else if (push) begin
            id_q     <= id_q + 16'd1;
            remain_q <= remain_q - 16'd1;
        end
    end
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= {lbase_q, gbase_q, pbase_q, stride_q, size_q, mask_q, flags_q, index_q, id_q};
    end
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
`ifdef MTSP_MEMCMD_ISSUE_STAT_EN
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            stat_issued <= stat_issued + 32'(pop);
            stat_stall  <= stat_stall + 32'((state == ISSUE) & full);
        end
    end
`endif
endmodule

// File: tb/tb_mtsp_memory_command_issue.sv
// tb_mtsp_memory_command_issue: table-driven and directed checks of command expansion, FIFO backpressure, wrap and reset.
module tb_mtsp_memory_command_issue;
    logic         CLK = 0;
    logic         nRST, req_valid, req_ready, cmd_valid, cmd_ready, busy;
    logic [3:0]   req_flags;
    logic [11:0]  req_index;
    logic [15:0]  req_id, req_count, req_mask, req_lbase, req_gbase;
    logic [7:0]   req_stride, req_size;
    logic [31:0]  req_pbase;
    logic [127:0] cmd;
`ifdef MTSP_MEMCMD_ISSUE_STAT_EN
    logic [31:0]  stat_issued, stat_stall;
`endif
    int checks = 0, failures = 0, pops_since_reset = 0;

    typedef struct {
        logic [15:0]  id, count;
        logic [3:0]   flags;
        logic [11:0]  index;
        logic [15:0]  mask;
        logic [7:0]   stride, size;
        logic [31:0]  pbase;
        logic [15:0]  lbase, gbase;
        logic [111:0] hi;
    } vec_t;
    vec_t vecs[4];
    vec_t v;

    always #5 CLK = ~CLK;

    mtsp_memory_command_issue #(.FIFO_DEPTH(4)) dut (
        .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(req_ready),
        .req_flags(req_flags), .req_index(req_index), .req_id(req_id), .req_count(req_count),
        .req_mask(req_mask), .req_stride(req_stride), .req_size(req_size), .req_pbase(req_pbase),
        .req_lbase(req_lbase), .req_gbase(req_gbase), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .busy(busy)
`ifdef MTSP_MEMCMD_ISSUE_STAT_EN
        , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic do_req(input vec_t r);
        req_valid = 1; req_flags = r.flags; req_index = r.index; req_id = r.id; req_count = r.count;
        req_mask = r.mask; req_stride = r.stride; req_size = r.size; req_pbase = r.pbase;
        req_lbase = r.lbase; req_gbase = r.gbase;
        chk("req_ready_at_request", 128'(req_ready), 128'd1);
        @(negedge CLK);
        req_valid = 0;
    endtask

    task automatic collect(input int n, input logic [15:0] id0, input logic [111:0] hi, input int budget);
        int got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            if (cmd_valid && cmd_ready) begin
                chk($sformatf("cmd_%0d", got), cmd, {hi, 16'(id0 + 16'(got))});
                got++;
                pops_since_reset++;
            end
            @(negedge CLK);
        end
        if (got < n) begin
            failures++; checks++;
            $display("FAIL collect_timeout got=%0d exp=%0d", got, n);
        end
    endtask

    task automatic wait_ready(input int budget);
        int c = 0;
        while (!req_ready && c < budget) begin @(negedge CLK); c++; end
        if (!req_ready) begin
            failures++; checks++;
            $display("FAIL wait_ready_timeout act=0 exp=1");
        end
    endtask

    initial begin
        vecs[0] = '{16'h0010, 16'd3, 4'b1010, 12'h005, 16'h00FF, 8'h04, 8'h10, 32'h80000000, 16'h0100, 16'h0200,
                    112'h01000200_80000000_041000FF_A005};
        vecs[1] = '{16'hFFFE, 16'd4, 4'b0101, 12'hABC, 16'h1234, 8'h08, 8'h20, 32'h12345678, 16'hBEEF, 16'hCAFE,
                    112'hBEEFCAFE_12345678_08201234_5ABC};
        vecs[2] = '{16'h0000, 16'd1, 4'b1111, 12'hFFF, 16'hFFFF, 8'hFF, 8'hFF, 32'hFFFFFFFF, 16'hFFFF, 16'h0000,
                    112'hFFFF0000_FFFFFFFF_FFFFFFFF_FFFF};
        vecs[3] = '{16'h1234, 16'd0, 4'b0011, 12'h111, 16'h0F0F, 8'h01, 8'h02, 32'h00001000, 16'h0001, 16'h0002,
                    112'h0};
        nRST = 0; req_valid = 0; cmd_ready = 1;
        req_flags = 0; req_index = 0; req_id = 0; req_count = 0; req_mask = 0;
        req_stride = 0; req_size = 0; req_pbase = 0; req_lbase = 0; req_gbase = 0;
        @(negedge CLK); @(negedge CLK);
        chk("rst_cmd_valid", 128'(cmd_valid), 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_busy", 128'(busy), 0);
        chk("rst_req_ready", 128'(req_ready), 1);
        nRST = 1;
        @(negedge CLK);

        // Basic issue: strict cycle-by-cycle timing.
        do_req(vecs[0]);
        chk("basic_latency_valid", 128'(cmd_valid), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk($sformatf("basic_valid_%0d", k), 128'(cmd_valid), 1);
            chk($sformatf("basic_cmd_%0d", k), cmd, {vecs[0].hi, 16'(16'h0010 + 16'(k))});
        end
        @(negedge CLK);
        chk("basic_busy_drop", 128'(busy), 0);
        chk("basic_cmd_zero", cmd, 0);

        // Table of requests with cmd_ready held high.
        for (int i = 0; i < 4; i++) begin
            wait_ready(20);
            do_req(vecs[i]);
            if (vecs[i].count == 0) begin
                for (int c = 0; c < 4; c++) begin
                    chk("zero_cmd_valid", 128'(cmd_valid), 0);
                    chk("zero_busy", 128'(busy), 0);
                    chk("zero_req_ready", 128'(req_ready), 1);
                    @(negedge CLK);
                end
            end else begin
                collect(int'(vecs[i].count), vecs[i].id, vecs[i].hi, int'(vecs[i].count) + 20);
                chk($sformatf("vec%0d_busy_end", i), 128'(busy), 0);
            end
        end

        // Backpressure: FIFO fills, FSM holds, head stays stable.
        v = '{16'h0300, 16'd6, 4'b1000, 12'h00A, 16'h000F, 8'h02, 8'h04, 32'h40000000, 16'h0010, 16'h0020,
              112'h00100020_40000000_0204000F_800A};
        cmd_ready = 0;
        do_req(v);
        @(negedge CLK);
        for (int c = 0; c < 10; c++) begin
            chk("bp_cmd_valid", 128'(cmd_valid), 1);
            chk("bp_cmd_stable", cmd, {v.hi, 16'h0300});
            chk("bp_req_ready", 128'(req_ready), 0);
            chk("bp_busy", 128'(busy), 1);
            @(negedge CLK);
        end
        cmd_ready = 1;
        collect(6, 16'h0300, v.hi, 30);
        chk("bp_busy_end", 128'(busy), 0);

        // Reset mid-issue.
        v = '{16'h0400, 16'd100, 4'b0001, 12'h123, 16'hAAAA, 8'h10, 8'h08, 32'hDEAD0000, 16'h0303, 16'h0404,
              112'h03030404_DEAD0000_1008AAAA_1123};
        do_req(v);
        collect(5, 16'h0400, v.hi, 20);
        nRST = 0;
        @(negedge CLK);
        nRST = 1;
        pops_since_reset = 0;
        chk("mid_rst_cmd_valid", 128'(cmd_valid), 0);
        chk("mid_rst_busy", 128'(busy), 0);
        chk("mid_rst_cmd", cmd, 0);
        chk("mid_rst_req_ready", 128'(req_ready), 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            chk("post_rst_no_cmd", 128'(cmd_valid), 0);
        end
        do_req(vecs[2]);
        collect(1, vecs[2].id, vecs[2].hi, 20);

        // Back-to-back requests: B presented as soon as req_ready returns.
        v = '{16'h0100, 16'd2, 4'b0110, 12'h0F0, 16'h5555, 8'h03, 8'h07, 32'h00ABCDEF, 16'h1111, 16'h2222,
              112'h11112222_00ABCDEF_03075555_60F0};
        do_req(v);
        fork
            begin
                vec_t b;
                b = v;
                b.id = 16'h0200;
                wait_ready(20);
                do_req(b);
            end
            begin
                collect(2, 16'h0100, v.hi, 20);
                collect(2, 16'h0200, v.hi, 20);
            end
        join
        chk("b2b_busy_end", 128'(busy), 0);
`ifdef MTSP_MEMCMD_ISSUE_STAT_EN
        chk("stat_issued", 128'(stat_issued), 128'(pops_since_reset));
        chk("stat_issued_five", 128'(stat_issued), 128'd5);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end
endmodule
